// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan controller with frame-aligned shadow load and guard gaps.
// Optional leading-zero suppression is enabled with SEG7_LEADING_ZERO_BLANK_EN.

module dec_7seg (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);
    always_comb begin
        seg = 7'b0000000;
        case (nibble)
            4'h0: seg = 7'b1111110;
            4'h1: seg = 7'b0110000;
            4'h2: seg = 7'b1101101;
            4'h3: seg = 7'b1111001;
            4'h4: seg = 7'b0110011;
            4'h5: seg = 7'b1011011;
            4'h6: seg = 7'b1011111;
            4'h7: seg = 7'b1110000;
            4'h8: seg = 7'b1111111;
            4'h9: seg = 7'b1111011;
            4'hA: seg = 7'b1110111;
            4'hB: seg = 7'b0011111;
            4'hC: seg = 7'b1001110;
            4'hD: seg = 7'b0111101;
            4'hE: seg = 7'b1001111;
            4'hF: seg = 7'b1000111;
            default: seg = 7'b0000000;
        endcase
    end
endmodule

// state | meaning
// GUARD | all digits off between slots, phase counts to GUARD_CYCLES-1
// ON    | digit ptr lit, phase counts to ON_CYCLES-1; last ON of final digit is the frame boundary
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int GUARD_CYCLES = 2,
    parameter int ON_CYCLES    = 50000
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      load_req,
    input  logic [4*NUM_DIGITS-1:0]   data_in,
    input  logic [NUM_DIGITS-1:0]     blank_mask,
    output logic                      load_ack,
    output logic [NUM_DIGITS-1:0]     digit_sel,
    output logic [6:0]                seg_out,
    output logic                      frame_start
);
    localparam int MAXC = (GUARD_CYCLES > ON_CYCLES) ? GUARD_CYCLES : ON_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int PW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] G_LAST = CW'(GUARD_CYCLES - 1);
    localparam logic [CW-1:0] O_LAST = CW'(ON_CYCLES - 1);
    localparam logic [PW-1:0] P_LAST = PW'(NUM_DIGITS - 1);

    typedef enum logic {GUARD = 1'b0, ON = 1'b1} state_t;

    state_t                    state, state_nx;
    logic [PW-1:0]             ptr, ptr_nx;
    logic [CW-1:0]             phase, phase_nx;
    logic                      running;
    logic                      load_now;
    logic [4*NUM_DIGITS-1:0]   shadow;
    logic [NUM_DIGITS-1:0]     blank;
    logic [3:0]                nib;
    logic [6:0]                seg_dec;

    // The first edge after reset only arms the scan, so the cycle after it is frame cycle 0.
    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        phase_nx = phase + 1'b1;
        load_now = 1'b0;
        if (!running) begin
            phase_nx = phase;
        end else begin
            case (state)
                GUARD: begin
                    if (phase == G_LAST) begin
                        state_nx = ON;
                        phase_nx = '0;
                    end
                end
                ON: begin
                    if (phase == O_LAST) begin
                        state_nx = GUARD;
                        phase_nx = '0;
                        ptr_nx   = (ptr == P_LAST) ? '0 : ptr + 1'b1;
                        load_now = load_req && (ptr == P_LAST);
                    end
                end
                default: begin
                    state_nx = GUARD;
                    phase_nx = '0;
                end
            endcase
        end
    end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    logic zero_above;
    always_comb begin
        blank      = blank_mask;
        zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above && (shadow[4*i +: 4] == 4'h0);
            if (zero_above) blank[i] = 1'b1;
        end
    end
`else
    always_comb begin
        blank = blank_mask;
    end
`endif

    assign nib = shadow[{ptr_nx, 2'b00} +: 4];

    dec_7seg u_dec (
        .nibble (nib),
        .seg    (seg_dec)
    );

    // Outputs are computed from the next state so they change on the same edge as state/ptr.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= GUARD;
            ptr         <= '0;
            phase       <= '0;
            running     <= 1'b0;
            shadow      <= '0;
            load_ack    <= 1'b0;
            digit_sel   <= '0;
            seg_out     <= '0;
            frame_start <= 1'b0;
        end else begin
            state       <= state_nx;
            ptr         <= ptr_nx;
            phase       <= phase_nx;
            running     <= 1'b1;
            if (load_now) shadow <= data_in;
            load_ack    <= load_now;
            frame_start <= (state_nx == GUARD) && (ptr_nx == '0) && (phase_nx == '0);
            digit_sel   <= (state_nx == ON) ? (NUM_DIGITS'(1) << ptr_nx) : '0;
            seg_out     <= ((state_nx == ON) && !blank[ptr_nx]) ? seg_dec : 7'b0000000;
        end
    end
endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Time-multiplexed scan controller for a bank of common-select 7-segment displays. It holds a shadow copy of an N-digit hex value and cycles one digit at a time through an internal `dec_7seg` instance, with a guard gap between digits to prevent ghosting. New values are accepted through a req/ack handshake, and only at frame boundaries, so a frame never shows a mix of old and new digits. It sits between the processor's display/debug register and the board's segment and digit-select pins.

## Interface
- `NUM_DIGITS`, 4: number of digits scanned; supported range 1–8.
- `GUARD_CYCLES`, 2: cycles per slot with all digits off; must be ≥1.
- `ON_CYCLES`, 50000: cycles per slot with the digit lit; must be ≥1.
- `clock` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: synchronous, active-high.
- `load_req` input 1: level request to load `data_in`.
- `data_in` input 4*NUM_DIGITS: hex value. Nibble i drives digit i; digit 0 is the rightmost. Must be held stable while `load_req` is high.
- `blank_mask` input NUM_DIGITS: bit i=1 forces digit i dark. Sampled live.
- `load_ack` output 1: one-cycle pulse when the shadow register has been updated.
- `digit_sel` output NUM_DIGITS: one-hot, active-high digit enable; all zero during guard.
- `seg_out` output 7: active-high segments a..g, with a at bit 6.
- `frame_start` output 1: one-cycle pulse on the first guard cycle of digit 0.

## Operation
- The FSM has two states:
  - GUARD lasts GUARD_CYCLES cycles, then moves to ON.
  - ON lasts ON_CYCLES cycles, then moves to GUARD and advances the digit pointer.
- Pointer behaviour:
  - The pointer counts 0..NUM_DIGITS-1 and wraps to 0.
  - A frame is NUM_DIGITS*(GUARD_CYCLES+ON_CYCLES) cycles.
- The phase counter is sized with $clog2 of max(GUARD_CYCLES, ON_CYCLES). It resets to 0 on every state change.
- During GUARD: `digit_sel`=0 and `seg_out`=0.
- During ON: `digit_sel`=1<<ptr.
  - `seg_out` is the decode of shadow nibble [ptr], unless the digit is blanked.
  - A blanked digit has `seg_out`=0 while `digit_sel` stays asserted.
- Load handshake:
  - On the last ON cycle of digit NUM_DIGITS-1, if `load_req`=1, then shadow ← `data_in`.
  - `load_ack` pulses on the following cycle.
  - The new value is first visible in the ON phase of digit 0 of the next frame.
  - `load_req` is level-sensitive. If it is still high at the next boundary, the block loads and acks again. The requester deasserts `load_req` on seeing `load_ack`.
  - A `load_req` that rises and falls between boundaries is not captured.
- Reset mid-scan aborts the current slot immediately. A pending request is dropped and no ack is issued.

## Timing
- Reset values:
  - State GUARD, ptr 0, phase counter 0, shadow 0.
  - `digit_sel`=0, `seg_out`=0, `load_ack`=0.
  - `frame_start`=0 while `reset` is high.
- First cycle after reset release:
  - `frame_start`=1.
  - ON for digit 0 begins GUARD_CYCLES cycles later.
- `digit_sel`, `seg_out`, `frame_start` and `load_ack` are all registered. `digit_sel` and `seg_out` change on the same edge as the state and pointer. There is no combinational path from any input to any output.
- `blank_mask` and `data_in` (on load) affect `seg_out` with exactly one register stage.
- `frame_start` period is exactly one frame. `load_ack` pulses at most once per frame.
- NUM_DIGITS=1: the pointer stays at 0, and every ON end is a frame boundary.

## Configuration
- Macro `SEG7_LEADING_ZERO_BLANK_EN`.
  - When defined: digit i (i≥1) is blanked if nibble i and every higher nibble of the shadow register are zero. Digit 0 is never suppressed by this rule. This is ORed with `blank_mask`.
  - When undefined: only `blank_mask` blanks digits, and zeros display as "0" (1111110).

## Test plan
Unless noted, all scenarios use NUM_DIGITS=4, GUARD_CYCLES=2, ON_CYCLES=6, giving a 32-cycle frame.

- **Reset and first frame.** Hold reset 3 cycles, then release.
  - All outputs are 0 during reset.
  - `frame_start` is high on cycle 0.
  - Cycles 0–1: `digit_sel`=0000.
  - Cycles 2–7: `digit_sel`=0001, `seg_out`=1111110.
  - Cycles 10–15: `digit_sel`=0010.
- **Load handshake.** Raise `load_req` with `data_in`=0x1234 at cycle 5.
  - `load_ack` pulses at cycle 32.
  - In the next frame:
    - digit0 shows 0110011.
    - digit1 shows 1111001.
    - digit2 shows 1101101.
    - digit3 shows 0110000.
- **Held request.** Hold `load_req` high for 70 cycles.
  - Exactly two `load_ack` pulses, 32 cycles apart.
  - A 1-cycle `load_req` at cycle 10 produces no ack.
- **Blank mask.** With shadow 0xABCD, set `blank_mask`=0100.
  - Digit2 slot: `digit_sel`=0100, `seg_out`=0000000.
  - The other digits decode normally, e.g. digit0 shows 0111101.
- **Reset mid-scan.** Assert reset during the digit2 ON phase while `load_req` is pending.
  - Next cycle: outputs are 0, the shadow register is 0, and no `load_ack` is issued.
- **Leading zeros** (macro defined).
  - Shadow 0x0012: digits 3 and 2 are dark; digit1 shows 0110000 and digit0 shows 1101101.
  - Shadow 0x0000: only digit0 shows 1111110.
  - Macro undefined, shadow 0x0012: digit3 shows 1111110.
